// File: rtl/uart_word_loader_if.sv
// Word-write bus from the UART image loader into the RAM programming port.
// The loader drives it through the master modport; the RAM side listens on slave.
interface uart_word_loader_if #(
    parameter int ADDR_W = 14
) ();
    logic              upg_wen_o;
    logic [ADDR_W-1:0] upg_adr_o;
    logic [31:0]       upg_dat_o;
    logic              upg_done_o;

    modport master (
        output upg_wen_o,
        output upg_adr_o,
        output upg_dat_o,
        output upg_done_o
    );

    modport slave (
        input  upg_wen_o,
        input  upg_adr_o,
        input  upg_dat_o,
        input  upg_done_o
    );
endinterface

// File: rtl/uart_word_loader.sv
// 8N1 UART receiver plus length-prefixed image parser that emits little-endian 32-bit word writes.
// Define UART_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before completion.
module uart_word_loader #(
    parameter int CLKS_PER_BIT = 87,
    parameter int ADDR_W       = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               rx_i,
    uart_word_loader_if.master upg,
    output logic               busy_o,
    output logic               frame_err_o
);
    localparam int               CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN_LO,
        LD_LEN_HI,
        LD_DATA,
`ifdef UART_LOADER_CHECKSUM_EN
        LD_CHK,
`endif
        LD_DONE
    } ld_state_t;

`ifdef UART_LOADER_CHECKSUM_EN
    localparam ld_state_t LD_AFTER_IMAGE = LD_CHK;
`else
    localparam ld_state_t LD_AFTER_IMAGE = LD_DONE;
`endif

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic             rx_fall;

    rx_state_t        rx_state;
    rx_state_t        rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt;
    logic [CNT_W-1:0] rx_cnt_nxt;
    logic [2:0]       rx_bit;
    logic [2:0]       rx_bit_nxt;
    logic [7:0]       rx_shift;
    logic [7:0]       rx_shift_nxt;
    logic             byte_valid;
    logic             byte_valid_nxt;
    logic             stop_err;
    logic             stop_err_nxt;

    ld_state_t         ld_state;
    ld_state_t         ld_state_nxt;
    logic [15:0]       len_q;
    logic [15:0]       len_nxt;
    logic [15:0]       word_cnt;
    logic [15:0]       word_cnt_nxt;
    logic [1:0]        byte_idx;
    logic [1:0]        byte_idx_nxt;
    logic [23:0]       word_buf;
    logic [23:0]       word_buf_nxt;
    logic [ADDR_W-1:0] next_adr;
    logic [ADDR_W-1:0] next_adr_nxt;
    logic              wen_q;
    logic              wen_nxt;
    logic [ADDR_W-1:0] adr_q;
    logic [ADDR_W-1:0] adr_nxt;
    logic [31:0]       dat_q;
    logic [31:0]       dat_nxt;
    logic              done_q;
    logic              done_nxt;
    logic              busy_q;
    logic              busy_nxt;
    logic              err_q;
    logic              err_nxt;

    // rx_i is asynchronous; rx_prev gives the synchronized falling edge for start detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            rx_state   <= rx_state_nxt;
            rx_cnt     <= rx_cnt_nxt;
            rx_bit     <= rx_bit_nxt;
            rx_shift   <= rx_shift_nxt;
            byte_valid <= byte_valid_nxt;
            stop_err   <= stop_err_nxt;
        end
    end

    always_comb begin
        rx_state_nxt   = rx_state;
        rx_cnt_nxt     = rx_cnt + 1'b1;
        rx_bit_nxt     = rx_bit;
        rx_shift_nxt   = rx_shift;
        byte_valid_nxt = 1'b0;
        stop_err_nxt   = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = '0;
                if (rx_fall) begin
                    rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_bit_nxt   = '0;
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == FULL_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                    rx_bit_nxt   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt == FULL_LAST) begin
                    rx_cnt_nxt     = '0;
                    rx_state_nxt   = RX_IDLE;
                    byte_valid_nxt = rx_sync;
                    stop_err_nxt   = ~rx_sync;
                end
            end
            default: begin
                rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_state <= LD_IDLE;
            len_q    <= '0;
            word_cnt <= '0;
            byte_idx <= '0;
            word_buf <= '0;
            next_adr <= '0;
            wen_q    <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ld_state <= ld_state_nxt;
            len_q    <= len_nxt;
            word_cnt <= word_cnt_nxt;
            byte_idx <= byte_idx_nxt;
            word_buf <= word_buf_nxt;
            next_adr <= next_adr_nxt;
            wen_q    <= wen_nxt;
            adr_q    <= adr_nxt;
            dat_q    <= dat_nxt;
            done_q   <= done_nxt;
            busy_q   <= busy_nxt;
            err_q    <= err_nxt;
        end
    end

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] chk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= '0;
        end else if (start_i) begin
            chk_q <= '0;
        end else if (byte_valid && (ld_state == LD_LEN_LO || ld_state == LD_LEN_HI ||
                                    ld_state == LD_DATA)) begin
            chk_q <= chk_q ^ rx_shift;
        end
    end
`endif

    // start_i outranks everything, so a byte landing in the same cycle is dropped.
    always_comb begin
        ld_state_nxt = ld_state;
        len_nxt      = len_q;
        word_cnt_nxt = word_cnt;
        byte_idx_nxt = byte_idx;
        word_buf_nxt = word_buf;
        next_adr_nxt = next_adr;
        wen_nxt      = 1'b0;
        adr_nxt      = adr_q;
        dat_nxt      = dat_q;
        done_nxt     = done_q;
        busy_nxt     = busy_q;
        err_nxt      = err_q | stop_err;
        if (start_i) begin
            ld_state_nxt = LD_LEN_LO;
            len_nxt      = '0;
            word_cnt_nxt = '0;
            byte_idx_nxt = '0;
            next_adr_nxt = '0;
            done_nxt     = 1'b0;
            busy_nxt     = 1'b1;
            err_nxt      = 1'b0;
        end else begin
            unique case (ld_state)
                LD_IDLE: begin
                end
                LD_LEN_LO: begin
                    if (byte_valid) begin
                        len_nxt[7:0] = rx_shift;
                        ld_state_nxt = LD_LEN_HI;
                    end
                end
                LD_LEN_HI: begin
                    if (byte_valid) begin
                        len_nxt[15:8] = rx_shift;
                        ld_state_nxt  = ({rx_shift, len_q[7:0]} == 16'd0) ? LD_AFTER_IMAGE
                                                                           : LD_DATA;
                    end
                end
                LD_DATA: begin
                    if (byte_valid) begin
                        byte_idx_nxt = byte_idx + 2'd1;
                        unique case (byte_idx)
                            2'd0: word_buf_nxt[7:0]   = rx_shift;
                            2'd1: word_buf_nxt[15:8]  = rx_shift;
                            2'd2: word_buf_nxt[23:16] = rx_shift;
                            default: begin
                                wen_nxt      = 1'b1;
                                dat_nxt      = {rx_shift, word_buf};
                                adr_nxt      = next_adr;
                                next_adr_nxt = next_adr + 1'b1;
                                word_cnt_nxt = word_cnt + 16'd1;
                                if (word_cnt == len_q - 16'd1) begin
                                    ld_state_nxt = LD_AFTER_IMAGE;
                                end
                            end
                        endcase
                    end
                end
`ifdef UART_LOADER_CHECKSUM_EN
                LD_CHK: begin
                    if (byte_valid) begin
                        ld_state_nxt = LD_DONE;
                        if (rx_shift != chk_q) begin
                            err_nxt = 1'b1;
                        end
                    end
                end
`endif
                // Registered here so done rises one cycle after the final strobe.
                LD_DONE: begin
                    done_nxt = 1'b1;
                    busy_nxt = 1'b0;
                end
                default: begin
                    ld_state_nxt = LD_IDLE;
                end
            endcase
        end
    end

    assign upg.upg_wen_o  = wen_q;
    assign upg.upg_adr_o  = adr_q;
    assign upg.upg_dat_o  = dat_q;
    assign upg.upg_done_o = done_q;
    assign busy_o         = busy_q;
    assign frame_err_o    = err_q;
endmodule
